deser8way: RTL

Serial-to-parallel deserializer: shifts a 1-bit stream, sampled under a `sin_valid` qualifier, into an 8-bit word. The word is presented on eight single-bit outputs `a`..`h` with the same port shape as the 8-input reduction gates. A one-word output register with a valid/ready handshake holds the result. The block adds a frame-resync timeout, sticky overflow reporting and optional parity checking. It sits between a serial link pin and the gate-level datapath blocks.

---
 rtl/deser8way_if.sv | 23 ++
 rtl/deser8way.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/deser8way_if.sv
// Bundle of the deser8way serial input, parallel word output and handshake signals.
// master: the link/consumer side; slave: the deserializer.
interface deser8way_if;
  logic sin;
  logic sin_valid;
  logic clr;
  logic out_ready;
  logic a, b, c, d, e, f, g, h;
  logic out_valid;
  logic ovf;
  logic tout;
  logic perr;

  modport master (
    output sin, sin_valid, clr, out_ready,
    input  a, b, c, d, e, f, g, h, out_valid, ovf, tout, perr
  );

  modport slave (
    input  sin, sin_valid, clr, out_ready,
    output a, b, c, d, e, f, g, h, out_valid, ovf, tout, perr
  );
endinterface

// File: rtl/deser8way.sv
// Serial-to-parallel deserializer with one-word output register, frame timeout and sticky overflow.
// Optional even-parity frame check enabled by defining DESER8WAY_PARITY_EN.
module deser8way #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst_n,
  deser8way_if.slave  bus
);

`ifdef DESER8WAY_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  idle_q, idle_d;
  logic [7:0]  word_q, word_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        tout_q, tout_d;
  logic        done;
  logic [7:0]  idle_inc;
`ifdef DESER8WAY_PARITY_EN
  logic        perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    word_d   = word_q;
    valid_d  = valid_q & ~bus.out_ready;
    ovf_d    = ovf_q & ~bus.clr;
    tout_d   = 1'b0;
    done     = 1'b0;
    idle_inc = idle_q + 8'd1;
`ifdef DESER8WAY_PARITY_EN
    perr_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        idle_d = '0;
        if (bus.sin_valid) begin
          shift_d = {7'd0, bus.sin};
          cnt_d   = 4'd1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.sin_valid) begin
          idle_d  = '0;
          shift_d = {shift_q[6:0], bus.sin};
          if (cnt_q == 4'd7) begin
`ifdef DESER8WAY_PARITY_EN
            cnt_d   = 4'd8;
            state_d = StPar;
`else
            done    = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
`endif
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
`ifdef DESER8WAY_PARITY_EN
      StPar: begin
        if (bus.sin_valid) begin
          // Even parity: XOR over all nine bits must be zero.
          if (^{shift_q, bus.sin}) perr_d = 1'b1;
          else                     done   = 1'b1;
          idle_d  = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (!bus.sin_valid && state_q != StIdle) begin
      idle_d = idle_inc;
      if (idle_inc == TimeoutLim) begin
        state_d = StIdle;
        shift_d = '0;
        cnt_d   = '0;
        idle_d  = '0;
        tout_d  = 1'b1;
      end
    end

    // shift_d already holds the completed data byte on the completing edge.
    if (done) begin
      if (!valid_q || bus.out_ready) begin
        word_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      tout_q  <= 1'b0;
`ifdef DESER8WAY_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      tout_q  <= tout_d;
`ifdef DESER8WAY_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h} = word_q;
  assign bus.out_valid = valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.tout      = tout_q;
`ifdef DESER8WAY_PARITY_EN
  assign bus.perr      = perr_q;
`else
  assign bus.perr      = 1'b0;
`endif

endmodule
